// File: rtl/mpc_qp_admm_vec_ram_2p_if.sv
// Port bundle for the ADMM vector RAM (two symmetric ports plus the clear sweep).
//
// Signals:
//   clear            start a clear sweep (sampled only while idle)
//   busy             high during every sweep cycle
//   address*/ce*/we*/d*  per-port request: ce qualifies the cycle, we selects write
//   q*               per-port read data
//   collision        one-cycle pulse after a same-address dual write
//   addr_err         one-cycle pulse after an out-of-range access on either port
//   dbg_state        current controller state (IDLE/CLEAR)
//
// Handshake: there is no ready/backpressure. A request is accepted in any cycle
// where ce is high and busy is low; requests raised while busy is high are
// dropped, not deferred. Read data appears a fixed latency after acceptance.
interface mpc_qp_admm_vec_ram_2p_if #(
    parameter int DataWidth    = 21,
    parameter int AddressWidth = 5
);
    logic                    clear;
    logic                    busy;
    logic [AddressWidth-1:0] address0;
    logic                    ce0;
    logic                    we0;
    logic [DataWidth-1:0]    d0;
    logic [DataWidth-1:0]    q0;
    logic [AddressWidth-1:0] address1;
    logic                    ce1;
    logic                    we1;
    logic [DataWidth-1:0]    d1;
    logic [DataWidth-1:0]    q1;
    logic                    collision;
    logic                    addr_err;
    logic [0:0]              dbg_state;

    modport master (
        output clear, address0, ce0, we0, d0, address1, ce1, we1, d1,
        input  busy, q0, q1, collision, addr_err, dbg_state
    );

    modport slave (
        input  clear, address0, ce0, we0, d0, address1, ce1, we1, d1,
        output busy, q0, q1, collision, addr_err, dbg_state
    );
endinterface

// File: rtl/mpc_qp_admm_vec_ram_2p.sv
// True dual-port word RAM used for ADMM vector storage, with a self-timed
// clear sweep, same-address write collision flag and out-of-range detection.
//
// Ports:
//   clk    clock, all logic on the rising edge
//   reset  synchronous active-high reset (does not touch RAM contents)
//   bus    slave side of mpc_qp_admm_vec_ram_2p_if (both ports, clear/busy,
//          collision, addr_err, dbg_state)
//
// Read latency is 1 cycle, or 2 with OutReg=1. Port 1 wins a same-address
// dual write. While the sweep runs, all port traffic and clear are ignored.
module mpc_qp_admm_vec_ram_2p #(
    parameter int                   DataWidth    = 21,
    parameter int                   AddressWidth = 5,
    parameter int                   AddressRange = 18,
    parameter int                   RdMode       = 0,
    parameter int                   OutReg       = 0,
    parameter logic [DataWidth-1:0] InitValue    = '0
) (
    input logic                     clk,
    input logic                     reset,
    mpc_qp_admm_vec_ram_2p_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    // One extra bit so AddressRange == 2**AddressWidth still compares correctly.
    localparam logic [AddressWidth:0]   RANGE_EXT = (AddressWidth + 1)'(AddressRange);
    localparam logic [AddressWidth-1:0] LAST_ADDR = AddressWidth'(AddressRange - 1);

    logic [0:0]              state;
    logic [AddressWidth-1:0] sweep_addr;
    logic [DataWidth-1:0]    mem [0:AddressRange-1];

    logic                    idle;
    logic                    valid0, valid1;
    logic                    acc0, acc1;
    logic                    wr0, wr1;
    logic                    col_next, err_next;
    logic [DataWidth-1:0]    rd0_next, rd1_next;
    logic [DataWidth-1:0]    s1_q0, s1_q1;
    logic                    collision_r, addr_err_r;

    assign idle   = (state == IDLE);
    assign valid0 = ({1'b0, bus.address0} < RANGE_EXT);
    assign valid1 = ({1'b0, bus.address1} < RANGE_EXT);

    // Port traffic only counts while idle; the sweep owns the array otherwise.
    assign acc0 = idle & bus.ce0;
    assign acc1 = idle & bus.ce1;
    assign wr0  = acc0 & bus.we0 & valid0;
    assign wr1  = acc1 & bus.we1 & valid1;

    assign col_next = wr0 & wr1 & (bus.address0 == bus.address1);
    assign err_next = (acc0 & ~valid0) | (acc1 & ~valid1);

    // ---------------- sweep controller ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sweep_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sweep_addr <= '0;
                    if (bus.clear) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (sweep_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        sweep_addr <= '0;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    sweep_addr <= '0;
                end
            endcase
        end
    end

    // ---------------- storage ----------------
    // No reset on the array: reset must leave contents intact, but a reset
    // cycle still suppresses every write, sweep writes included. Port 1 is
    // written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!idle) begin
                mem[sweep_addr] <= InitValue;
            end else begin
                if (wr0) begin
                    mem[bus.address0] <= bus.d0;
                end
                if (wr1) begin
                    mem[bus.address1] <= bus.d1;
                end
            end
        end
    end

    // ---------------- read path ----------------
    // The array lookup sees pre-write contents, so a cross-port read of an
    // address being written returns the old word. Write-first only bypasses
    // the port's own d.
    always_comb begin
        rd0_next = '0;
        if (valid0) begin
            if (RdMode == 1 && bus.we0) begin
                rd0_next = bus.d0;
            end else begin
                rd0_next = mem[bus.address0];
            end
        end
    end

    always_comb begin
        rd1_next = '0;
        if (valid1) begin
            if (RdMode == 1 && bus.we1) begin
                rd1_next = bus.d1;
            end else begin
                rd1_next = mem[bus.address1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q0 <= '0;
            s1_q1 <= '0;
        end else begin
            if (acc0) begin
                s1_q0 <= rd0_next;
            end
            if (acc1) begin
                s1_q1 <= rd1_next;
            end
        end
    end

    generate
        if (OutReg != 0) begin : g_out_reg
            logic [DataWidth-1:0] s2_q0, s2_q1;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_q0 <= '0;
                    s2_q1 <= '0;
                end else begin
                    s2_q0 <= s1_q0;
                    s2_q1 <= s1_q1;
                end
            end

            assign bus.q0 = s2_q0;
            assign bus.q1 = s2_q1;
        end else begin : g_no_out_reg
            assign bus.q0 = s1_q0;
            assign bus.q1 = s1_q1;
        end
    endgenerate

    // ---------------- status flags ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            collision_r <= 1'b0;
            addr_err_r  <= 1'b0;
        end else begin
            collision_r <= col_next;
            addr_err_r  <= err_next;
        end
    end

    assign bus.collision = collision_r;
    assign bus.addr_err  = addr_err_r;
    assign bus.busy      = (state == CLEAR);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_mpc_qp_admm_vec_ram_2p.sv
module tb_mpc_qp_admm_vec_ram_2p;
    localparam int DW = 21;
    localparam int AW = 5;
    localparam int AR = 18;
    localparam logic [DW-1:0] INIT = 21'h5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // bus0 drives the read-first/unregistered RAM; bus1 mirrors its inputs
    // into a write-first RAM with the extra output stage.
    mpc_qp_admm_vec_ram_2p_if #(.DataWidth(DW), .AddressWidth(AW)) bus0 ();
    mpc_qp_admm_vec_ram_2p_if #(.DataWidth(DW), .AddressWidth(AW)) bus1 ();

    assign bus1.clear    = bus0.clear;
    assign bus1.address0 = bus0.address0;
    assign bus1.ce0      = bus0.ce0;
    assign bus1.we0      = bus0.we0;
    assign bus1.d0       = bus0.d0;
    assign bus1.address1 = bus0.address1;
    assign bus1.ce1      = bus0.ce1;
    assign bus1.we1      = bus0.we1;
    assign bus1.d1       = bus0.d1;

    mpc_qp_admm_vec_ram_2p #(
        .DataWidth(DW), .AddressWidth(AW), .AddressRange(AR),
        .RdMode(0), .OutReg(0), .InitValue(INIT)
    ) u_rf (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    mpc_qp_admm_vec_ram_2p #(
        .DataWidth(DW), .AddressWidth(AW), .AddressRange(AR),
        .RdMode(1), .OutReg(1), .InitValue(INIT)
    ) u_wf (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [DW-1:0] exp_mem [AR];
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [AW-1:0] a0;
        logic          ce0;
        logic          we0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a1;
        logic          ce1;
        logic          we1;
        logic [DW-1:0] d1;
        logic [DW-1:0] q0;
        logic [DW-1:0] q1;
        logic          col;
        logic          err;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(
        input logic [AW-1:0] a0, input logic ce0, input logic we0, input logic [DW-1:0] d0,
        input logic [AW-1:0] a1, input logic ce1, input logic we1, input logic [DW-1:0] d1,
        input logic [DW-1:0] q0, input logic [DW-1:0] q1, input logic col, input logic err);
        vec_t v;
        v.a0 = a0; v.ce0 = ce0; v.we0 = we0; v.d0 = d0;
        v.a1 = a1; v.ce1 = ce1; v.we1 = we1; v.d1 = d1;
        v.q0 = q0; v.q1 = q1; v.col = col; v.err = err;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        bus0.clear    = 1'b0;
        bus0.address0 = '0;
        bus0.ce0      = 1'b0;
        bus0.we0      = 1'b0;
        bus0.d0       = '0;
        bus0.address1 = '0;
        bus0.ce1      = 1'b0;
        bus0.we1      = 1'b0;
        bus0.d1       = '0;
    endtask

    // Reads every word on both ports of both RAMs against exp_mem.
    task automatic read_all(input string tag);
        logic [DW-1:0] e;
        for (int a = 0; a < AR; a++) begin
            idle_ports();
            bus0.address0 = AW'(a);
            bus0.address1 = AW'(a);
            bus0.ce0      = 1'b1;
            bus0.ce1      = 1'b1;
            exp_q.push_back(exp_mem[a]);
            tick();
            e = exp_q.pop_front();
            chk($sformatf("%s_rf_q0_a%0d", tag, a), 32'(bus0.q0), 32'(e));
            chk($sformatf("%s_rf_q1_a%0d", tag, a), 32'(bus0.q1), 32'(e));
            idle_ports();
            tick();
            chk($sformatf("%s_wf_q0_a%0d", tag, a), 32'(bus1.q0), 32'(e));
            chk($sformatf("%s_wf_q1_a%0d", tag, a), 32'(bus1.q1), 32'(e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        int n_busy;
        int side_bad;

        tbl[0]  = mk(5'd3,  1, 1, 21'h1ABCD,  5'd3,  1, 0, 21'h0,     21'h5,     21'h5,     0, 0);
        tbl[1]  = mk(5'd0,  0, 0, 21'h0,      5'd3,  1, 0, 21'h0,     21'h5,     21'h1ABCD, 0, 0);
        tbl[2]  = mk(5'd5,  1, 1, 21'h00055,  5'd0,  0, 0, 21'h0,     21'h5,     21'h1ABCD, 0, 0);
        tbl[3]  = mk(5'd5,  1, 0, 21'h0,      5'd3,  1, 0, 21'h0,     21'h55,    21'h1ABCD, 0, 0);
        tbl[4]  = mk(5'd7,  1, 1, 21'h11,     5'd7,  1, 1, 21'h22,    21'h5,     21'h5,     1, 0);
        tbl[5]  = mk(5'd0,  0, 0, 21'h0,      5'd0,  0, 0, 21'h0,     21'h5,     21'h5,     0, 0);
        tbl[6]  = mk(5'd7,  1, 0, 21'h0,      5'd20, 1, 0, 21'h0,     21'h22,    21'h0,     0, 1);
        tbl[7]  = mk(5'd0,  0, 0, 21'h0,      5'd0,  0, 0, 21'h0,     21'h22,    21'h0,     0, 0);
        tbl[8]  = mk(5'd20, 1, 1, 21'h77,     5'd0,  1, 0, 21'h0,     21'h0,     21'h5,     0, 1);
        tbl[9]  = mk(5'd31, 1, 1, 21'h1FFFFF, 5'd17, 1, 1, 21'hAAAA,  21'h0,     21'h5,     0, 1);
        tbl[10] = mk(5'd17, 1, 0, 21'h0,      5'd4,  1, 0, 21'h0,     21'hAAAA,  21'h5,     0, 0);
        tbl[11] = mk(5'd20, 1, 1, 21'h33,     5'd20, 1, 1, 21'h44,    21'h0,     21'h0,     0, 1);
        tbl[12] = mk(5'd1,  1, 1, 21'h123,    5'd2,  1, 1, 21'h456,   21'h5,     21'h5,     0, 0);
        tbl[13] = mk(5'd2,  1, 0, 21'h0,      5'd1,  1, 0, 21'h0,     21'h456,   21'h123,   0, 0);
        tbl[14] = mk(5'd0,  1, 0, 21'h0,      5'd0,  1, 1, 21'h9,     21'h5,     21'h5,     0, 0);
        tbl[15] = mk(5'd0,  1, 0, 21'h0,      5'd16, 1, 0, 21'h0,     21'h9,     21'h5,     0, 0);
        tbl[16] = mk(5'd6,  0, 1, 21'hBAD,    5'd0,  0, 0, 21'h0,     21'h9,     21'h5,     0, 0);

        // Reset wins over a simultaneous clear and write.
        reset = 1'b1;
        idle_ports();
        bus0.clear    = 1'b1;
        bus0.ce0      = 1'b1;
        bus0.we0      = 1'b1;
        bus0.address0 = 5'd3;
        bus0.d0       = 21'h1;
        tick();
        tick();
        chk("rst_busy",      32'(bus0.busy),      32'd0);
        chk("rst_state",     32'(bus0.dbg_state), 32'd0);
        chk("rst_q0",        32'(bus0.q0),        32'd0);
        chk("rst_q1",        32'(bus0.q1),        32'd0);
        chk("rst_collision", 32'(bus0.collision), 32'd0);
        chk("rst_addr_err",  32'(bus0.addr_err),  32'd0);
        chk("rst_wf_q0",     32'(bus1.q0),        32'd0);
        chk("rst_wf_busy",   32'(bus1.busy),      32'd0);
        reset = 1'b0;
        idle_ports();
        tick();
        chk("post_rst_busy", 32'(bus0.busy), 32'd0);

        // Full sweep; ports hammer the RAM and clear stays high throughout.
        bus0.clear = 1'b1;
        tick();
        chk("sweep_start_busy", 32'(bus0.busy), 32'd1);
        n_busy   = 0;
        side_bad = 0;
        for (int k = 0; k < 100 && bus0.busy; k++) begin
            n_busy++;
            if (bus0.collision || bus0.addr_err || bus1.collision || bus1.addr_err ||
                bus0.q0 !== 21'h0 || bus0.q1 !== 21'h0) begin
                side_bad++;
            end
            bus0.clear    = 1'b1;
            bus0.ce0      = 1'b1;
            bus0.we0      = 1'b1;
            bus0.address0 = 5'd2;
            bus0.d0       = 21'h3FF;
            bus0.ce1      = 1'b1;
            bus0.we1      = 1'b1;
            bus0.address1 = (k % 2 == 1) ? 5'd25 : 5'd2;
            bus0.d1       = 21'h1FF;
            tick();
        end
        idle_ports();
        chk("sweep_busy_cycles", 32'(n_busy),   32'd18);
        chk("sweep_side_effects", 32'(side_bad), 32'd0);
        tick();
        chk("sweep_no_restart", 32'(bus0.busy), 32'd0);

        for (int a = 0; a < AR; a++) exp_mem[a] = INIT;
        read_all("clr");

        // Directed port vectors.
        for (int i = 0; i < 17; i++) begin
            bus0.clear    = 1'b0;
            bus0.address0 = tbl[i].a0;
            bus0.ce0      = tbl[i].ce0;
            bus0.we0      = tbl[i].we0;
            bus0.d0       = tbl[i].d0;
            bus0.address1 = tbl[i].a1;
            bus0.ce1      = tbl[i].ce1;
            bus0.we1      = tbl[i].we1;
            bus0.d1       = tbl[i].d1;
            tick();
            chk($sformatf("vec%0d_q0", i),     32'(bus0.q0),        32'(tbl[i].q0));
            chk($sformatf("vec%0d_q1", i),     32'(bus0.q1),        32'(tbl[i].q1));
            chk($sformatf("vec%0d_col", i),    32'(bus0.collision), 32'(tbl[i].col));
            chk($sformatf("vec%0d_err", i),    32'(bus0.addr_err),  32'(tbl[i].err));
            chk($sformatf("vec%0d_wf_col", i), 32'(bus1.collision), 32'(tbl[i].col));
            chk($sformatf("vec%0d_wf_err", i), 32'(bus1.addr_err),  32'(tbl[i].err));
        end
        idle_ports();

        // Write-first bypass and two-stage latency vs read-first.
        bus0.ce0      = 1'b1;
        bus0.address0 = 5'd0;
        tick();
        chk("wf_seq_rf_rd0", 32'(bus0.q0), 32'h9);
        bus0.we0      = 1'b1;
        bus0.address0 = 5'd5;
        bus0.d0       = 21'h99;
        tick();
        chk("wf_seq_rf_old",   32'(bus0.q0), 32'h55);
        chk("wf_seq_wf_stage", 32'(bus1.q0), 32'h9);
        idle_ports();
        tick();
        chk("wf_seq_rf_hold", 32'(bus0.q0), 32'h55);
        chk("wf_seq_wf_new",  32'(bus1.q0), 32'h99);
        idle_ports();

        exp_mem[0]  = 21'h9;
        exp_mem[1]  = 21'h123;
        exp_mem[2]  = 21'h456;
        exp_mem[3]  = 21'h1ABCD;
        exp_mem[5]  = 21'h99;
        exp_mem[7]  = 21'h22;
        exp_mem[17] = 21'hAAAA;
        read_all("tbl");

        // Clear alongside port writes, then reset in the 6th sweep cycle.
        bus0.clear    = 1'b1;
        bus0.ce0      = 1'b1;
        bus0.we0      = 1'b1;
        bus0.address0 = 5'd10;
        bus0.d0       = 21'h77;
        bus0.ce1      = 1'b1;
        bus0.we1      = 1'b1;
        bus0.address1 = 5'd4;
        bus0.d1       = 21'h66;
        tick();
        chk("mid_busy_start", 32'(bus0.busy), 32'd1);
        chk("mid_q0_old",     32'(bus0.q0),   32'h5);
        idle_ports();
        repeat (5) tick();
        chk("mid_busy_6th", 32'(bus0.busy), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy",  32'(bus0.busy),      32'd0);
        chk("mid_rst_q0",    32'(bus0.q0),        32'd0);
        chk("mid_rst_q1",    32'(bus0.q1),        32'd0);
        chk("mid_rst_wf_q0", 32'(bus1.q0),        32'd0);
        chk("mid_rst_wf_q1", 32'(bus1.q1),        32'd0);
        chk("mid_rst_col",   32'(bus0.collision), 32'd0);
        chk("mid_rst_err",   32'(bus0.addr_err),  32'd0);
        reset = 1'b0;
        tick();
        chk("mid_idle_busy", 32'(bus0.busy), 32'd0);

        for (int a = 0; a < 5; a++) exp_mem[a] = INIT;
        exp_mem[10] = 21'h77;
        read_all("rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
